// File: rtl/rx_peak_detector.sv
// rx_peak_detector
// Picks the strongest of NUM_CODES correlation channels for every sample,
// arms when that magnitude crosses ithreshold, tracks the true peak over a
// fixed window of samples and strobes code / timestamp / magnitude once.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a stage-2 best magnitude strictly above threshold
// S_SEARCH  | inside the window, keeping the largest (earliest on ties) peak
// S_REPORT  | single-cycle strobe of the latched peak
// S_HOLDOFF | counting ignored samples before re-arming
module rx_peak_detector #(
    parameter int NUM_CODES   = 16,
    parameter int CORR_WIDTH  = 41,
    parameter int WINDOW_LEN  = 64,
    parameter int HOLDOFF_LEN = 256,
    parameter int TS_WIDTH    = 32,
    localparam int CODE_W     = $clog2(NUM_CODES),
    localparam int MAG_W      = CORR_WIDTH - 1
) (
    input  logic                            crx_clk,
    input  logic                            rrx_rst,
    input  logic                            erx_en,
    input  logic                            icorr_valid,
    input  logic [NUM_CODES*CORR_WIDTH-1:0] icorrelation_results,
    input  logic [MAG_W-1:0]                ithreshold,
    output logic                            odetect_valid,
    output logic [CODE_W-1:0]               odetect_code,
    output logic [TS_WIDTH-1:0]             odetect_time,
    output logic [MAG_W-1:0]                odetect_peak,
    output logic                            obusy
);

    localparam int WIN_W  = 16;
    localparam int HOLD_W = $clog2(HOLDOFF_LEN + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEARCH  = 2'd1,
        S_REPORT  = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                            in_valid;
    logic [NUM_CODES*CORR_WIDTH-1:0] in_data;
    logic [TS_WIDTH-1:0]             ts_cnt;
    logic [TS_WIDTH-1:0]             in_tag;

    logic                            s1_valid;
    logic [MAG_W-1:0]                s1_mag [NUM_CODES];
    logic [TS_WIDTH-1:0]             s1_tag;

    logic [MAG_W-1:0]                arg_mag;
    logic [CODE_W-1:0]               arg_code;

    logic                            s2_valid;
    logic [MAG_W-1:0]                s2_mag;
    logic [CODE_W-1:0]               s2_code;
    logic [TS_WIDTH-1:0]             s2_tag;

    logic [MAG_W-1:0]                peak_mag;
    logic [CODE_W-1:0]               peak_code;
    logic [TS_WIDTH-1:0]             peak_tag;

    logic [MAG_W-1:0]                rep_mag;
    logic [CODE_W-1:0]               rep_code;
    logic [TS_WIDTH-1:0]             rep_tag;

    logic [WIN_W-1:0]                win_cnt, win_cnt_nxt;
    logic [HOLD_W-1:0]               hold_cnt, hold_cnt_nxt;
    logic                            peak_load;

    // |v| in MAG_W bits; only the most negative code has bit MAG_W set after
    // negation, and that one saturates to all ones.
    function automatic logic [MAG_W-1:0] abs_sat(input logic [CORR_WIDTH-1:0] v);
        logic [CORR_WIDTH-1:0] u;
        u = v[CORR_WIDTH-1] ? (~v + CORR_WIDTH'(1)) : v;
        if (u[MAG_W])
            return '1;
        return u[MAG_W-1:0];
    endfunction

    // Accept a result set and stamp it with the pre-increment timestamp
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            in_valid <= 1'b0;
            ts_cnt   <= '0;
        end else if (erx_en) begin
            in_valid <= icorr_valid;
            if (icorr_valid)
                ts_cnt <= ts_cnt + TS_WIDTH'(1);
        end
    end

    // Input data register; contents qualified by in_valid, so no reset
    always_ff @(posedge crx_clk) begin
        if (erx_en && icorr_valid) begin
            in_data <= icorrelation_results;
            in_tag  <= ts_cnt;
        end
    end

    // Pipeline valid flags, frozen with erx_en
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (erx_en) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
        end
    end

    // Stage 1: per-code saturated magnitude
    always_ff @(posedge crx_clk) begin
        if (erx_en) begin
            for (int k = 0; k < NUM_CODES; k++)
                s1_mag[k] <= abs_sat(in_data[k*CORR_WIDTH +: CORR_WIDTH]);
            s1_tag <= in_tag;
        end
    end

    // Argmax with strict compare so the lowest index wins a tie
    always_comb begin
        arg_mag  = s1_mag[0];
        arg_code = '0;
        for (int k = 1; k < NUM_CODES; k++) begin
            if (s1_mag[k] > arg_mag) begin
                arg_mag  = s1_mag[k];
                arg_code = CODE_W'(k);
            end
        end
    end

    // Stage 2: register the strongest code of the set
    always_ff @(posedge crx_clk) begin
        if (erx_en) begin
            s2_mag  <= arg_mag;
            s2_code <= arg_code;
            s2_tag  <= s1_tag;
        end
    end

    // FSM state register
    always_ff @(posedge crx_clk) begin
        if (rrx_rst)
            state <= S_IDLE;
        else if (erx_en)
            state <= state_nxt;
    end

    // FSM next state plus window / holdoff counter updates
    always_comb begin
        state_nxt    = state;
        win_cnt_nxt  = win_cnt;
        hold_cnt_nxt = hold_cnt;
        peak_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (s2_valid && (s2_mag > ithreshold)) begin
                    peak_load   = 1'b1;
                    win_cnt_nxt = WIN_W'(1);
                    state_nxt   = (WINDOW_LEN == 1) ? S_REPORT : S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (s2_valid) begin
                    if (s2_mag > peak_mag)
                        peak_load = 1'b1;
                    win_cnt_nxt = win_cnt + WIN_W'(1);
                    if (win_cnt_nxt == WIN_W'(WINDOW_LEN))
                        state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                // a sample arriving during the strobe is the first holdoff sample
                if (HOLDOFF_LEN == 0) begin
                    state_nxt = S_IDLE;
                end else begin
                    hold_cnt_nxt = s2_valid ? HOLD_W'(1) : '0;
                    state_nxt    = (hold_cnt_nxt == HOLD_W'(HOLDOFF_LEN)) ? S_IDLE : S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (s2_valid) begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                    if (hold_cnt_nxt == HOLD_W'(HOLDOFF_LEN))
                        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters, latched peak and the held report values
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            win_cnt   <= '0;
            hold_cnt  <= '0;
            peak_mag  <= '0;
            peak_code <= '0;
            peak_tag  <= '0;
            rep_mag   <= '0;
            rep_code  <= '0;
            rep_tag   <= '0;
        end else if (erx_en) begin
            win_cnt  <= win_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
            if (peak_load) begin
                peak_mag  <= s2_mag;
                peak_code <= s2_code;
                peak_tag  <= s2_tag;
            end
            if (state == S_REPORT) begin
                rep_mag  <= peak_mag;
                rep_code <= peak_code;
                rep_tag  <= peak_tag;
            end
        end
    end

    // Outputs: live peak during the strobe, held copy afterwards
    always_comb begin
        odetect_valid = (state == S_REPORT);
        obusy         = (state != S_IDLE);
        if (state == S_REPORT) begin
            odetect_code = peak_code;
            odetect_time = peak_tag;
            odetect_peak = peak_mag;
        end else begin
            odetect_code = rep_code;
            odetect_time = rep_tag;
            odetect_peak = rep_mag;
        end
    end

endmodule

// File: tb/tb_rx_peak_detector.sv
// Testbench for rx_peak_detector: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// sample-level reference model.
module tb_rx_peak_detector;

    localparam int NC = 16;
    localparam int CW = 41;
    localparam int MW = 40;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam longint MAXMAG = 64'h0000_00FF_FFFF_FFFF;

    logic              crx_clk;
    logic              rrx_rst;
    logic              erx_en;
    logic              icorr_valid;
    logic [NC*CW-1:0]  icorrelation_results;
    logic [MW-1:0]     ithreshold;
    logic              odetect_valid;
    logic [3:0]        odetect_code;
    logic [31:0]       odetect_time;
    logic [MW-1:0]     odetect_peak;
    logic              obusy;

    rx_peak_detector #(
        .NUM_CODES(NC), .CORR_WIDTH(CW), .WINDOW_LEN(W), .HOLDOFF_LEN(H), .TS_WIDTH(32)
    ) dut (
        .crx_clk(crx_clk), .rrx_rst(rrx_rst), .erx_en(erx_en),
        .icorr_valid(icorr_valid), .icorrelation_results(icorrelation_results),
        .ithreshold(ithreshold), .odetect_valid(odetect_valid),
        .odetect_code(odetect_code), .odetect_time(odetect_time),
        .odetect_peak(odetect_peak), .obusy(obusy)
    );

    initial begin
        crx_clk = 1'b0;
        forever #5 crx_clk = ~crx_clk;
    end

    int vectors = 0;
    int miscompares = 0;
    int nprint = 0;

    // ---------------- reference model (sample level) ----------------
    typedef struct {
        bit          v;
        longint      mag;
        logic [3:0]  code;
        logic [31:0] tag;
    } samp_t;

    typedef struct {
        longint code;
        longint tm;
        longint pk;
        int     edge_n;
    } obs_t;

    samp_t       sr [3];
    samp_t       ev;
    bit          started = 1'b0;
    int          edge_no = 0;
    logic [31:0] m_ts;
    bit          m_rep;
    int          m_win_left;
    int          m_hold_left;
    longint      pk_mag;
    logic [3:0]  pk_code;
    logic [31:0] pk_tag;
    logic [3:0]  e_code;
    logic [31:0] e_time;
    logic [MW-1:0] e_peak;
    int          acc_edge [int];
    obs_t        obs [$];

    function automatic void best_of(input logic [NC*CW-1:0] d, output longint bm, output logic [3:0] bc);
        logic signed [CW-1:0] v;
        longint m;
        bm = 0;
        bc = 0;
        for (int k = 0; k < NC; k++) begin
            v = d[k*CW +: CW];
            m = longint'(v);
            if (m < 0) m = -m;
            if (m > MAXMAG) m = MAXMAG;
            if (m > bm) begin
                bm = m;
                bc = 4'(k);
            end
        end
    endfunction

    task automatic take_peak();
        pk_mag  = ev.mag;
        pk_code = ev.code;
        pk_tag  = ev.tag;
    endtask

    task automatic fire();
        m_rep  = 1'b1;
        e_code = pk_code;
        e_time = pk_tag;
        e_peak = pk_mag[MW-1:0];
    endtask

    initial begin : model
        longint     bm;
        logic [3:0] bc;
        forever begin
            @(posedge crx_clk);
            edge_no++;
            if (rrx_rst) begin
                started = 1'b1;
                m_ts = 0;
                for (int i = 0; i < 3; i++) sr[i].v = 1'b0;
                m_rep = 1'b0;
                m_win_left = 0;
                m_hold_left = 0;
                e_code = 0;
                e_time = 0;
                e_peak = 0;
            end else if (erx_en) begin
                ev = sr[2];
                sr[2] = sr[1];
                sr[1] = sr[0];
                sr[0].v = icorr_valid;
                if (icorr_valid) begin
                    best_of(icorrelation_results, bm, bc);
                    sr[0].mag = bm;
                    sr[0].code = bc;
                    sr[0].tag = m_ts;
                    acc_edge[int'(m_ts)] = edge_no;
                    m_ts = m_ts + 1;
                end
                if (m_rep) begin
                    m_rep = 1'b0;
                    if (H > 0) m_hold_left = H - (ev.v ? 1 : 0);
                end else if (m_hold_left > 0) begin
                    if (ev.v) m_hold_left--;
                end else if (m_win_left > 0) begin
                    if (ev.v) begin
                        if (ev.mag > pk_mag) take_peak();
                        m_win_left--;
                        if (m_win_left == 0) fire();
                    end
                end else if (ev.v && ev.mag > longint'(ithreshold)) begin
                    take_peak();
                    m_win_left = W - 1;
                    if (m_win_left == 0) fire();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        bit e_busy;
        bit prev_v = 1'b0;
        obs_t o;
        forever begin
            @(negedge crx_clk);
            if (started) begin
                e_busy = m_rep || (m_win_left > 0) || (m_hold_left > 0);
                vectors++;
                if (odetect_valid !== m_rep || obusy !== e_busy || odetect_code !== e_code ||
                    odetect_time !== e_time || odetect_peak !== e_peak) begin
                    miscompares++;
                    if (nprint < 10) begin
                        nprint++;
                        $display("FAIL cycle %0d: valid %0b exp %0b, busy %0b exp %0b, code %0d exp %0d, time %0d exp %0d, peak %0d exp %0d",
                                 edge_no, odetect_valid, m_rep, obusy, e_busy, odetect_code, e_code,
                                 odetect_time, e_time, odetect_peak, e_peak);
                    end
                end
                if (odetect_valid === 1'b1 && !prev_v) begin
                    o.code = longint'(odetect_code);
                    o.tm = longint'(odetect_time);
                    o.pk = longint'(odetect_peak);
                    o.edge_n = edge_no;
                    obs.push_back(o);
                end
                prev_v = (odetect_valid === 1'b1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input bit v, input bit en_i);
        icorr_valid = v;
        erx_en = en_i;
        @(posedge crx_clk);
        #1;
        icorr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rrx_rst = 1'b1;
        cyc(1'b0, 1'b1);
        rrx_rst = 1'b0;
    endtask

    task automatic send(input logic [NC*CW-1:0] d);
        icorrelation_results = d;
        cyc(1'b1, 1'b1);
    endtask

    function automatic logic [NC*CW-1:0] one_code(input int k, input longint val);
        logic [NC*CW-1:0] d;
        logic [63:0] t;
        d = '0;
        t = val;
        d[k*CW +: CW] = t[CW-1:0];
        return d;
    endfunction

    function automatic logic [NC*CW-1:0] rand_set();
        logic [NC*CW-1:0] d;
        logic [63:0] t;
        longint base;
        int mode;
        int mk;
        mode = $urandom_range(0, 9);
        base = longint'($urandom_range(1000, 20000));
        mk = $urandom_range(0, NC - 1);
        for (int k = 0; k < NC; k++) begin
            case (mode)
                0: t = longint'($urandom_range(0, 1998)) - 999;
                1: t = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? base : -base)
                                                   : longint'($urandom_range(0, 500));
                2: t = {$urandom(), $urandom()};
                default: t = longint'($urandom_range(0, 40000)) - 20000;
            endcase
            d[k*CW +: CW] = t[CW-1:0];
            if (mode == 3 && k == mk) d[k*CW +: CW] = {1'b1, {MW{1'b0}}};
        end
        return d;
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        logic [NC*CW-1:0] d;
        longint vals [8];
        int n0;
        int n_new;
        rrx_rst = 1'b1;
        erx_en = 1'b0;
        icorr_valid = 1'b0;
        icorrelation_results = '0;
        ithreshold = 40'd1000;
        #1;

        // 1: zeros never cross, ts counts accepted sets
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send('0);
            idle(2);
        end
        idle(5);
        chk("t1 ts_cnt", longint'(dut.ts_cnt), 10);
        chk("t1 busy", longint'(obusy), 0);

        // 2: rising then falling on code 5
        do_reset();
        n0 = obs.size();
        vals = '{0, 0, 0, 500, 2000, 3000, 2500, 0};
        for (int i = 0; i < 8; i++) begin
            send(one_code(5, vals[i]));
            idle(2);
        end
        idle(8);
        n_new = obs.size() - n0;
        chk("t2 count", n_new, 1);
        if (n_new > 0) begin
            chk("t2 code", obs[n0].code, 5);
            chk("t2 time", obs[n0].tm, 5);
            chk("t2 peak", obs[n0].pk, 3000);
            chk("t2 latency", obs[n0].edge_n - acc_edge[7], 3);
        end

        // 3: tie between -3000 and +3000, later equal value ignored
        do_reset();
        n0 = obs.size();
        d = one_code(2, -3000) | one_code(9, 3000);
        send(d);
        send(one_code(4, 3000));
        send(one_code(7, 100));
        send(one_code(7, 100));
        idle(8);
        n_new = obs.size() - n0;
        chk("t3 count", n_new, 1);
        if (n_new > 0) begin
            chk("t3 code", obs[n0].code, 2);
            chk("t3 time", obs[n0].tm, 0);
            chk("t3 peak", obs[n0].pk, 3000);
        end

        // 4: most negative input saturates
        do_reset();
        n0 = obs.size();
        d = '0;
        d[CW-1] = 1'b1;
        send(d);
        for (int i = 0; i < 3; i++) send('0);
        idle(8);
        n_new = obs.size() - n0;
        chk("t4 count", n_new, 1);
        if (n_new > 0) begin
            chk("t4 code", obs[n0].code, 0);
            chk("t4 peak", obs[n0].pk, MAXMAG);
        end

        // 5: crossings on every sample, back to back
        do_reset();
        n0 = obs.size();
        for (int i = 0; i < 20; i++) send(one_code(1, 5000));
        idle(6);
        n_new = obs.size() - n0;
        chk("t5 count", n_new, 3);
        if (n_new > 0) chk("t5 first time", obs[n0].tm, 0);
        for (int i = n0 + 1; i < obs.size(); i++)
            chk("t5 spacing", obs[i].tm - obs[i-1].tm, W + H);

        // 6a: reset mid-search aborts (samples 18,19 still searching)
        chk("t6 busy before rst", longint'(obusy), 1);
        n0 = obs.size();
        do_reset();
        chk("t6 valid after rst", longint'(odetect_valid), 0);
        chk("t6 peak after rst", longint'(odetect_peak), 0);
        chk("t6 time after rst", longint'(odetect_time), 0);
        idle(10);
        chk("t6 no strobe", obs.size() - n0, 0);
        send(one_code(3, 9000));
        for (int i = 0; i < 3; i++) begin
            idle(1);
            send('0);
        end
        idle(8);
        n_new = obs.size() - n0;
        chk("t6a count", n_new, 1);
        if (n_new > 0) chk("t6a time", obs[n0].tm, 0);

        // 6b: erx_en low for 50 cycles while the last sample is in flight
        send('0);
        send('0);
        n0 = obs.size();
        send(one_code(6, 7000));
        send('0);
        send('0);
        send('0);
        repeat (50) cyc(1'b0, 1'b0);
        idle(10);
        n_new = obs.size() - n0;
        chk("t6b count", n_new, 1);
        if (n_new > 0) begin
            chk("t6b code", obs[n0].code, 6);
            chk("t6b time", obs[n0].tm, 6);
            chk("t6b peak", obs[n0].pk, 7000);
            chk("t6b latency", obs[n0].edge_n - acc_edge[9], 53);
        end

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) ithreshold = 40'($urandom_range(0, 25000));
            if ($urandom_range(0, 299) == 0) do_reset();
            send(rand_set());
            repeat ($urandom_range(0, 3)) idle(1);
            if ($urandom_range(0, 9) == 0)
                repeat ($urandom_range(1, 5)) cyc($urandom_range(0, 1) == 1, 1'b0);
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
